// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   req_valid/req_ready [1:0]     per-requester request handshake
//   req_op*/req_a*/req_b*         opcode and operands per requester
//   rsp_valid/rsp_ready [1:0]     per-requester response handshake
//   rsp_o, rsp_z/of/neg           captured result and flags, shared
//   alu_opcode/alu_port_a/b       registered operands to the ALU
//   alu_port_o, alu_z/of/neg      combinational ALU result and flags
//   grant_cnt0/1                  saturating accepted-operation counts
package alu_arbiter_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} aluop_t;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_INIT = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  aluop_t           req_op0,
    input  aluop_t           req_op1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_o,
    output logic             rsp_z,
    output logic             rsp_of,
    output logic             rsp_neg,
    output aluop_t           alu_opcode,
    output logic [31:0]      alu_port_a,
    output logic [31:0]      alu_port_b,
    input  logic [31:0]      alu_port_o,
    input  logic             alu_z,
    input  logic             alu_of,
    input  logic             alu_neg,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state, w_next;
    logic             r_prio, r_owner;
    aluop_t           r_op;
    logic [31:0]      r_a, r_b;
    logic [34:0]      r_res;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;
    logic             w_win, w_acc;
    logic [1:0]       w_ready;

    always_comb begin
        // a lone requester wins outright; prio only breaks ties
        w_win   = (req_valid == 2'b11) ? r_prio : req_valid[1];
        w_ready = (r_state == IDLE && !RST && |req_valid) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        w_acc   = |w_ready;
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? EXEC : IDLE;
            EXEC:    w_next = RESP;
            RESP:    w_next = rsp_ready[r_owner] ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_prio  <= RR_INIT;
            r_owner <= 1'b0;
            r_op    <= ALU_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_owner <= w_win;
                r_prio  <= !w_win;
                r_op    <= w_win ? req_op1 : req_op0;
                r_a     <= w_win ? req_a1 : req_a0;
                r_b     <= w_win ? req_b1 : req_b0;
                if (w_win)
                    r_cnt1 <= (&r_cnt1) ? r_cnt1 : r_cnt1 + 1'b1;
                else
                    r_cnt0 <= (&r_cnt0) ? r_cnt0 : r_cnt0 + 1'b1;
            end
            // ALU has seen the new operands for a full cycle by the end of EXEC
            if (r_state == EXEC)
                r_res <= {alu_port_o, alu_z, alu_of, alu_neg};
        end
    end

    assign req_ready  = w_ready;
    assign rsp_valid  = (r_state == RESP && !RST) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign {rsp_o, rsp_z, rsp_of, rsp_neg} = r_res;
    assign alu_opcode = r_op;
    assign alu_port_a = r_a;
    assign alu_port_b = r_b;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
endmodule
